fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the RV32I core. It sits directly upstream of the decode/branch stage: it owns the program counter, issues one word fetch at a time to instruction memory over a valid/ready handshake, and hands each fetched word plus its PC to decode through a one-entry output register. Taken-branch and jump targets computed downstream (the branch unit's next-PC result) come back on the redirect port. A redirect flushes in-flight work and restarts fetch at the target.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ireq_valid  out  1  fetch request valid
- ireq_ready  in  1  memory accepts the request this cycle
- iaddr  out  32  fetch address; valid while ireq_valid
- irsp_valid  in  1  response word valid; at most one per accepted request, any cycle after acceptance
- irsp_data  in  32  fetched instruction word
- instr_valid  out  1  output register holds a valid instruction
- instr_ready  in  1  decode consumes the instruction this cycle
- idata  out  32  instruction word to decode
- instr_pc  out  32  PC of idata
- redirect_valid  in  1  single-cycle next-PC override from the branch/jump logic
- redirect_pc  in  32  redirect target
- fetch_misaligned  out  1  sticky flag: last redirect target was not word aligned

## Operation
- State machine with states IDLE, REQ, WAIT, HOLD, ERR.
- IDLE: entered only by reset; moves to REQ on the first clock after reset release.
- REQ: ireq_valid=1, iaddr=pc.
  - On ireq_valid&ireq_ready: req_pc<=pc, pc<=pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), go to WAIT.
- WAIT: one request outstanding.
  - On irsp_valid with kill=0: idata<=irsp_data, instr_pc<=req_pc, instr_valid<=1, go to HOLD.
  - On irsp_valid with kill=1: drop the word, clear kill, go to REQ.
- HOLD: the output register is full and no request is issued.
  - When instr_valid&instr_ready: instr_valid<=0, go to REQ.
- Redirect has the highest priority in every state:
  - pc<=redirect_pc, instr_valid<=0 (flush), fetch_misaligned<=0.
  - If a request is outstanding after this edge, set kill=1. This covers WAIT without irsp_valid, and REQ with the handshake completing in the same cycle. Next state is then WAIT.
  - Otherwise next state is REQ.
  - redirect_pc[1:0]!=0: fetch_misaligned<=1, next state ERR. kill is still set if a request is outstanding.
- ERR: ireq_valid=0 and instr_valid=0. A pending kill response is absorbed (drop, clear kill). The block leaves ERR only on an aligned redirect (to REQ, or to WAIT if kill is still set) or on reset.
- Only one request is ever outstanding, and no new request is issued while kill=1.
- The output register is a plain hold register; idata and instr_pc are stable while instr_valid=1 and instr_ready=0.

## Timing
- Reset values (asynchronous, on reset=0):
  - pc=RESET_PC, req_pc=0, state=IDLE, kill=0.
  - ireq_valid=0, iaddr=RESET_PC.
  - instr_valid=0, idata=32'h0000_0013 (NOP), instr_pc=0.
  - fetch_misaligned=0.
- First ireq_valid appears 1 cycle after reset deasserts.
- Best-case throughput, with ireq_ready=1, a response one cycle after acceptance, and decode always ready: one instruction every 3 cycles (REQ, WAIT, HOLD).
- Latency: instr_valid rises on the clock edge that samples irsp_valid.
- Simultaneous cases:
  - redirect_valid and instr_ready in the same cycle: flush wins, and the held instruction is treated as discarded.
  - redirect_valid and irsp_valid in WAIT: the response is dropped, kill stays 0, next state REQ at redirect_pc.
  - ireq_ready while ireq_valid=0: ignored.
  - irsp_valid in any state other than WAIT or ERR-with-kill: ignored.
- Reset mid-operation clears kill. A memory response arriving after reset release but before the first new acceptance is ignored.

## Test plan
- Reset and sequential fetch:
  - Stimulus: RESET_PC=32'h0000_0100, memory always ready with 1-cycle response, decode always ready.
  - Required: iaddr sequence 100,104,108; instr_pc matches each; one instr_valid pulse every 3 cycles.
- Backpressure:
  - Stimulus: hold instr_ready=0 for 5 cycles with a valid instruction at PC 104.
  - Required: idata and instr_pc stable; ireq_valid=0 throughout; next fetch is 108 after release.
- Redirect with outstanding request:
  - Stimulus: accept the fetch of 108, pulse redirect_pc=32'h0000_0040, then return the response for 108.
  - Required: response dropped; no instr_valid for 108; next iaddr=40; first delivered instr_pc=40.
- Redirect coincident with response and with the handshake:
  - Stimulus: both orderings.
  - Required: no stale instruction is delivered; next iaddr is the target.
- Misaligned target:
  - Stimulus: redirect_pc=32'h0000_0042.
  - Required: fetch_misaligned=1, no fetch issued.
  - Stimulus: a later redirect_pc=32'h0000_0080.
  - Required: flag clears and fetch resumes at 80.
- Wrap-around and async reset:
  - Stimulus: redirect to FFFF_FFFC.
  - Required: next fetch after it is 0000_0000.
  - Stimulus: assert reset while in WAIT.
  - Required: all outputs at reset values immediately, without a clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, keeps a single word fetch in flight
// and presents each fetched word with its PC to decode through a one-entry register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    input  logic        ireq_ready,
    output logic [31:0] iaddr,
    input  logic        irsp_valid,
    input  logic [31:0] irsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] idata,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misaligned
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        ERR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        kill_q, kill_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] idata_q, idata_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        misaligned_q, misaligned_d;

    logic        req_fire;
    logic        outstanding;

    assign ireq_valid       = (state_q == REQ) && !kill_q;
    assign iaddr            = pc_q;
    assign instr_valid      = instr_valid_q;
    assign idata            = idata_q;
    assign instr_pc         = instr_pc_q;
    assign fetch_misaligned = misaligned_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        kill_d        = kill_q;
        instr_valid_d = instr_valid_q;
        idata_d       = idata_q;
        instr_pc_d    = instr_pc_q;
        misaligned_d  = misaligned_q;

        req_fire = ireq_valid && ireq_ready;
        // A request is still in flight after this edge unless its response is consumed now.
        outstanding = req_fire
                   || (((state_q == WAIT) || ((state_q == ERR) && kill_q)) && !irsp_valid);

        if (redirect_valid) begin
            pc_d          = redirect_pc;
            instr_valid_d = 1'b0;
            kill_d        = outstanding;
            if (redirect_pc[1:0] != 2'b00) begin
                misaligned_d = 1'b1;
                state_d      = ERR;
            end else begin
                misaligned_d = 1'b0;
                state_d      = outstanding ? WAIT : REQ;
            end
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (req_fire) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (irsp_valid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = REQ;
                        end else begin
                            idata_d       = irsp_data;
                            instr_pc_d    = req_pc_q;
                            instr_valid_d = 1'b1;
                            state_d       = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (instr_valid_q && instr_ready) begin
                        instr_valid_d = 1'b0;
                        state_d       = REQ;
                    end
                end
                ERR: begin
                    if (kill_q && irsp_valid) begin
                        kill_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            req_pc_q      <= 32'h0000_0000;
            kill_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            idata_q       <= 32'h0000_0013;
            instr_pc_q    <= 32'h0000_0000;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            kill_q        <= kill_d;
            instr_valid_q <= instr_valid_d;
            idata_q       <= idata_d;
            instr_pc_q    <= instr_pc_d;
            misaligned_q  <= misaligned_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed phases then random traffic, checked against a
// program-order model (delivered PCs follow each redirect target in steps of 4).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic        ireq_ready;
    logic [31:0] iaddr;
    logic        irsp_valid;
    logic [31:0] irsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] idata;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_misaligned;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk              (clk),
        .reset            (reset),
        .ireq_valid       (ireq_valid),
        .ireq_ready       (ireq_ready),
        .iaddr            (iaddr),
        .irsp_valid       (irsp_valid),
        .irsp_data        (irsp_data),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .idata            (idata),
        .instr_pc         (instr_pc),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // reference model state
    int          cyc = 0, n_req = 0, n_del = 0, last_del_cyc = -1;
    logic        tp_on = 1'b0;
    logic [31:0] exp_fetch, exp_del, last_hs_addr, last_del_pc;
    logic        exp_mis = 1'b0;
    logic        mem_pend = 1'b0;
    logic [31:0] mem_addr;
    int          mem_dly = 0;

    // stimulus knobs
    int          dly_fix  = 0;
    int          rdy_mode = 0;
    int          dec_mode = 1;
    logic        rnd_spur = 1'b0, rnd_redir = 1'b0;
    logic        redir_go = 1'b0, redir_on_req = 1'b0;
    logic [31:0] redir_tgt = 32'h0;
    int          d0, r0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5EED_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_outputs();
        chk1("rst_ireq_valid", ireq_valid, 1'b0);
        chk ("rst_iaddr", iaddr, 32'h0000_0100);
        chk1("rst_instr_valid", instr_valid, 1'b0);
        chk ("rst_idata", idata, 32'h0000_0013);
        chk ("rst_instr_pc", instr_pc, 32'h0000_0000);
        chk1("rst_misaligned", fetch_misaligned, 1'b0);
    endtask

    // One cycle: sample at the falling edge, check, then drive inputs for the next rising edge.
    task automatic cycle();
        logic hs, del;
        @(negedge clk);
        cyc++;
        chk1("misaligned", fetch_misaligned, exp_mis);
        if (exp_mis) begin
            chk1("err_ireq_valid", ireq_valid, 1'b0);
            chk1("err_instr_valid", instr_valid, 1'b0);
        end
        if (ireq_valid) chk1("one_outstanding", mem_pend, 1'b0);

        if (rdy_mode == 0) ireq_ready = 1'b1;
        else               ireq_ready = 1'($urandom_range(0, 1));
        if (dec_mode == 0)      instr_ready = 1'b0;
        else if (dec_mode == 1) instr_ready = 1'b1;
        else                    instr_ready = ($urandom_range(0, 3) != 0);

        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        if (redir_go) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_tgt;
            redir_go       = 1'b0;
        end else if (redir_on_req && ireq_valid) begin
            ireq_ready     = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = redir_tgt;
            redir_on_req   = 1'b0;
        end else if (rnd_redir && $urandom_range(0, 29) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = $urandom & 32'h0003_FFFC;
            if ($urandom_range(0, 7) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
        end

        irsp_valid = 1'b0;
        irsp_data  = $urandom;
        if (mem_pend) begin
            if (mem_dly == 0) begin
                irsp_valid = 1'b1;
                irsp_data  = memfn(mem_addr);
                mem_pend   = 1'b0;
            end else begin
                mem_dly--;
            end
        end else if (rnd_spur && $urandom_range(0, 15) == 0) begin
            irsp_valid = 1'b1;
        end

        hs = ireq_valid && ireq_ready;
        if (hs) begin
            chk("iaddr", iaddr, exp_fetch);
            last_hs_addr = iaddr;
            exp_fetch    = exp_fetch + 32'd4;
            n_req++;
            mem_pend = 1'b1;
            mem_addr = iaddr;
            mem_dly  = (dly_fix >= 0) ? dly_fix : int'($urandom_range(0, 3));
        end

        del = instr_valid && instr_ready && !redirect_valid;
        if (del) begin
            chk("instr_pc", instr_pc, exp_del);
            chk("idata", idata, memfn(exp_del));
            $display("deliver pc=%08h data=%08h cycle=%0d", instr_pc, idata, cyc);
            last_del_pc = instr_pc;
            if (tp_on && last_del_cyc >= 0) chk("spacing", 32'(cyc - last_del_cyc), 32'd3);
            last_del_cyc = cyc;
            exp_del      = exp_del + 32'd4;
            n_del++;
        end

        if (redirect_valid) begin
            exp_fetch = redirect_pc;
            exp_del   = redirect_pc;
            exp_mis   = (redirect_pc[1:0] != 2'b00);
        end
    endtask

    task automatic wait_deliveries(input int n, input int bound, input string tag);
        d0 = n_del;
        for (int k = 0; k < bound && n_del < d0 + n; k++) cycle();
        chk(tag, 32'(n_del - d0), 32'(n));
    endtask

    task automatic wait_request(input int bound, input string tag);
        r0 = n_req;
        for (int k = 0; k < bound && n_req == r0; k++) cycle();
        chk(tag, 32'(n_req - r0), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        ireq_ready = 1'b0; irsp_valid = 1'b0; irsp_data = 32'h0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        exp_fetch = 32'h0000_0100;
        exp_del   = 32'h0000_0100;
        #12;
        chk_reset_outputs();

        // reset release and sequential fetch
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk1("idle_no_req", ireq_valid, 1'b0);
        cycle();
        chk1("first_req", ireq_valid, 1'b1);
        chk ("first_iaddr", iaddr, 32'h0000_0100);
        wait_deliveries(1, 20, "t_first_del");
        chk("first_pc", last_del_pc, 32'h0000_0100);

        // backpressure on the instruction at 104
        dec_mode = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (instr_valid) break;
        end
        chk1("bp_valid", instr_valid, 1'b1);
        chk ("bp_pc", instr_pc, 32'h0000_0104);
        repeat (5) begin
            cycle();
            chk ("bp_pc_stable", instr_pc, 32'h0000_0104);
            chk ("bp_data_stable", idata, memfn(32'h0000_0104));
            chk1("bp_no_req", ireq_valid, 1'b0);
        end
        dec_mode = 1;
        dly_fix  = 3;
        wait_request(20, "t_req_108");
        chk("after_bp_iaddr", last_hs_addr, 32'h0000_0108);

        // redirect while the 108 fetch is outstanding
        redir_tgt = 32'h0000_0040;
        redir_go  = 1'b1;
        cycle();
        dly_fix = 0;
        wait_deliveries(1, 30, "t_del_40");
        chk("redir_pc_40", last_del_pc, 32'h0000_0040);

        // best-case throughput
        tp_on = 1'b1;
        last_del_cyc = -1;
        wait_deliveries(3, 40, "t_tp");
        tp_on = 1'b0;

        // redirect coincident with the response
        wait_request(20, "t_req_coinc");
        redir_tgt = 32'h0000_0200;
        redir_go  = 1'b1;
        cycle();
        wait_deliveries(1, 30, "t_del_200");
        chk("coinc_rsp_pc", last_del_pc, 32'h0000_0200);

        // redirect coincident with the request handshake
        redir_tgt    = 32'h0000_0300;
        redir_on_req = 1'b1;
        for (int k = 0; k < 20 && redir_on_req; k++) cycle();
        chk1("t_redir_on_req", redir_on_req, 1'b0);
        wait_deliveries(1, 30, "t_del_300");
        chk("coinc_hs_pc", last_del_pc, 32'h0000_0300);

        // misaligned target, then recovery
        redir_tgt = 32'h0000_0042;
        redir_go  = 1'b1;
        cycle();
        r0 = n_req;
        repeat (6) cycle();
        chk1("mis_flag", fetch_misaligned, 1'b1);
        chk ("mis_no_fetch", 32'(n_req - r0), 32'd0);
        redir_tgt = 32'h0000_0080;
        redir_go  = 1'b1;
        cycle();
        cycle();
        chk1("mis_cleared", fetch_misaligned, 1'b0);
        wait_deliveries(1, 30, "t_del_80");
        chk("resume_pc_80", last_del_pc, 32'h0000_0080);

        // wrap-around
        redir_tgt = 32'hFFFF_FFFC;
        redir_go  = 1'b1;
        cycle();
        wait_deliveries(2, 30, "t_wrap");
        chk("wrap_pc", last_del_pc, 32'h0000_0000);

        // random traffic
        rdy_mode = 1; dec_mode = 2; dly_fix = -1;
        rnd_redir = 1'b1; rnd_spur = 1'b1;
        repeat (3000) cycle();
        rnd_redir = 1'b0; rnd_spur = 1'b0;
        redir_tgt = 32'h0000_1000;
        redir_go  = 1'b1;
        cycle();
        wait_deliveries(1, 200, "t_del_1000");
        chk("rand_end_pc", last_del_pc, 32'h0000_1000);

        // asynchronous reset while waiting on memory
        rdy_mode = 0; dec_mode = 1; dly_fix = 5;
        wait_request(20, "t_req_before_reset");
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs();
        ireq_ready = 1'b0; irsp_valid = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        mem_pend  = 1'b0;
        exp_fetch = 32'h0000_0100;
        exp_del   = 32'h0000_0100;
        exp_mis   = 1'b0;
        dly_fix   = 0;
        @(negedge clk);
        irsp_valid = 1'b1;
        irsp_data  = 32'hDEAD_BEEF;
        reset      = 1'b1;
        wait_deliveries(1, 30, "t_del_after_reset");
        chk("post_reset_pc", last_del_pc, 32'h0000_0100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
